prng_sched: RTL and testbench
=============================

PRNG_SCHED -- requirements
Module: prng_sched

Interface
REQ-001 Parameter NREQ, default 4: number of byte requesters, 2..8.
REQ-002 Parameter WARM_CYCLES, default 16: LFSR steps discarded after each seed load, 1..255.
REQ-003 Port clk  input  1  clock; all state updates on rising edge.
REQ-004 Port rst  input  1  reset, synchronous, active-low.
REQ-005 Port seed_val  input  32  seed for the LFSR.
REQ-006 Port seed_ld  input  1  one-cycle pulse requesting a reseed.
REQ-007 Port req  input  NREQ  per-requester request for one random byte.
REQ-008 Port gnt  output  NREQ  one-hot grant; a byte is delivered in the grant cycle.
REQ-009 Port rnd_byte  output  8  random byte, valid when rnd_vld=1.
REQ-010 Port rnd_vld  output  1  rnd_byte valid; equals OR of gnt.
REQ-011 Port busy  output  1  high in LOAD and WARM states.
REQ-012 Port lfsr_ld  output  1  drives the LFSR load strobe.
REQ-013 Port lfsr_ldval  output  32  drives the LFSR load value.
REQ-014 Port lfsr_step  output  1  drives the LFSR step strobe.
REQ-015 Port lfsr_val  input  32  current LFSR value.

Function
REQ-016 The FSM SHALL have the states UNSEEDED, LOAD, WARM and SERVE; after reset it SHALL be in UNSEEDED.
REQ-017 In UNSEEDED, req SHALL be ignored, gnt=0, and seed_ld=1 SHALL move the FSM to LOAD on the next edge.
REQ-018 In LOAD (exactly one cycle), lfsr_ld=1 with lfsr_ldval=seed_val captured at the seed_ld cycle; next state is WARM.
REQ-019 A captured seed of 32'h0 SHALL be replaced by 32'h0000_0001, because all-zero is a lock-up state.
REQ-020 In WARM, lfsr_step=1 each cycle; a counter SHALL count WARM_CYCLES steps, then the FSM SHALL move to SERVE.
REQ-021 In SERVE, when any req bit is set, exactly one gnt bit SHALL be asserted in the same cycle; selection is round-robin, starting from the index after the last granted one (index 0 after each seed).
REQ-022 In the grant cycle, rnd_byte = lfsr_val[7:0]^lfsr_val[15:8]^lfsr_val[23:16]^lfsr_val[31:24], rnd_vld=1 and lfsr_step=1; the next grant therefore sees a fresh value (throughput one byte per cycle).
REQ-023 In SERVE with req=0, gnt=0, lfsr_step=0 and the LFSR holds.
REQ-024 seed_ld=1 in any state other than UNSEEDED SHALL take priority: gnt=0 and lfsr_step=0 that cycle, then LOAD; the round-robin pointer resets to 0.
REQ-025 When requests are held continuously, they SHALL be granted in rotating order with no requester starved for more than NREQ-1 cycles.
REQ-026 lfsr_ld and lfsr_step SHALL never both be 1.

Reset
REQ-027 When rst=0 at an edge: state=UNSEEDED, warm counter=0, RR pointer=0, captured seed=0; gnt, rnd_vld, lfsr_ld, lfsr_step and busy=0; rnd_byte=8'h00.
REQ-028 Reset asserted mid-WARM or mid-SERVE SHALL abort the operation with no further strobes; the LFSR is not reloaded.

Configuration
REQ-029 Macro PRNG_SCHED_WARMUP_EN: when defined, WARM behaves as in REQ-020; when undefined, LOAD goes directly to SERVE, WARM and its counter are absent, and busy is high only in LOAD.

Structure
REQ-030 A shared package prng_pkg SHALL hold the state enum type, the constants SEED_NONZERO (32'h0000_0001) and BYTE_W (8), and the byte-fold function.
REQ-031 The round-robin selector SHALL be a sub-module rr_arb (NREQ-wide request, one-hot grant, pointer update on grant); the existing lfsr is instantiated by the parent, not inside prng_sched.

Verification
REQ-032 Reset, then req=4'b1111 with no seed: gnt=0 and rnd_vld=0 for 20 cycles.
REQ-033 seed_ld with seed_val=32'hDEAD_BEEF: lfsr_ld for 1 cycle with lfsr_ldval=32'hDEAD_BEEF; lfsr_step for exactly 16 cycles; busy high for 17 cycles; then SERVE.
REQ-034 seed_val=0: lfsr_ldval=32'h0000_0001.
REQ-035 In SERVE, req=4'b1011 held: gnt sequence 0001,0010,1000,0001,...; rnd_byte equals the fold of lfsr_val each cycle; lfsr_step high every cycle.
REQ-036 seed_ld during a grant stream: gnt=0 in that cycle; next grant goes to index 0 after WARM completes.
REQ-037 Build without PRNG_SCHED_WARMUP_EN: after the LOAD cycle, the next cycle grants req immediately.

Source files
------------

// File: rtl/prng_pkg.sv
// Shared definitions for the random-byte scheduler.
// Holds the FSM state type, the lock-up-free substitute seed, the byte
// width and the 32-to-8 bit fold used to form each delivered byte.
package prng_pkg;

    typedef enum logic [1:0] {
        ST_UNSEEDED = 2'd0,
        ST_LOAD     = 2'd1,
        ST_WARM     = 2'd2,
        ST_SERVE    = 2'd3
    } state_t;

    localparam logic [31:0] SEED_NONZERO = 32'h0000_0001;
    localparam int          BYTE_W       = 8;

    function automatic logic [BYTE_W-1:0] byte_fold(input logic [31:0] v);
        return v[7:0] ^ v[15:8] ^ v[23:16] ^ v[31:24];
    endfunction

endpackage

// File: rtl/prng_sched_rr_arb.sv
// rr_arb: round-robin arbiter.
// Ports:
//   clk, rst (sync, active-low)
//   req [NREQ]  request vector
//   en          grants allowed this cycle
//   clr         force the search pointer back to index 0
//   gnt [NREQ]  one-hot grant (combinational)
// The search starts at the index after the last granted requester.
module rr_arb #(
    parameter int NREQ = 4
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [NREQ-1:0] req,
    input  logic            en,
    input  logic            clr,
    output logic [NREQ-1:0] gnt
);

    localparam int            PW   = (NREQ > 1) ? $clog2(NREQ) : 1;
    localparam logic [PW-1:0] LAST = PW'(NREQ - 1);

    logic [PW-1:0] ptr;
    logic [PW-1:0] gidx;
    logic          hit;

    always_comb begin
        int idx;
        idx  = 0;
        gnt  = '0;
        gidx = ptr;
        hit  = 1'b0;
        for (int off = 0; off < NREQ; off++) begin
            idx = (int'(ptr) + off) % NREQ;
            if (en && !hit && req[idx]) begin
                gnt[idx] = 1'b1;
                gidx     = PW'(idx);
                hit      = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            ptr <= '0;
        end else if (clr) begin
            ptr <= '0;
        end else if (hit) begin
            ptr <= (gidx == LAST) ? '0 : gidx + 1'b1;
        end
    end

endmodule

// File: rtl/prng_sched.sv
// prng_sched: seeds an external 32-bit LFSR, optionally discards a warm-up
// run of steps, then hands out one folded random byte per cycle to NREQ
// requesters in round-robin order.
// Ports:
//   clk, rst (sync, active-low)
//   seed_val[32], seed_ld     reseed request (priority in every state)
//   req[NREQ] / gnt[NREQ]     requests / one-hot grant, same cycle
//   rnd_byte[8], rnd_vld      byte delivered in the grant cycle
//   busy                      loading or warming up
//   lfsr_ld, lfsr_ldval[32]   load strobe/value to the LFSR
//   lfsr_step                 step strobe to the LFSR
//   lfsr_val[32]              current LFSR value
// Build option: define PRNG_SCHED_WARMUP_EN to insert WARM_CYCLES discarded
// LFSR steps after every load; otherwise LOAD goes straight to SERVE.
//
// state    | meaning
// UNSEEDED | no seed yet, requests ignored
// LOAD     | one cycle, LFSR loaded with captured seed
// WARM     | discarding WARM_CYCLES steps (warm-up builds only)
// SERVE    | granting bytes, one per cycle
module prng_sched
    import prng_pkg::*;
#(
    parameter int NREQ        = 4,
    parameter int WARM_CYCLES = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [31:0]       seed_val,
    input  logic              seed_ld,
    input  logic [NREQ-1:0]   req,
    output logic [NREQ-1:0]   gnt,
    output logic [BYTE_W-1:0] rnd_byte,
    output logic              rnd_vld,
    output logic              busy,
    output logic              lfsr_ld,
    output logic [31:0]       lfsr_ldval,
    output logic              lfsr_step,
    input  logic [31:0]       lfsr_val
);

    if (NREQ < 2 || NREQ > 8) begin : g_bad_nreq
        $error("prng_sched: NREQ out of range 2..8");
    end
    if (WARM_CYCLES < 1 || WARM_CYCLES > 255) begin : g_bad_warm
        $error("prng_sched: WARM_CYCLES out of range 1..255");
    end

    state_t      state, state_nxt;
    logic [31:0] seed_q;
    logic        arb_en;

`ifdef PRNG_SCHED_WARMUP_EN
    logic [7:0] warm_cnt;
`endif

    // State register, seed capture and warm-up down-counter.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state  <= ST_UNSEEDED;
            seed_q <= '0;
`ifdef PRNG_SCHED_WARMUP_EN
            warm_cnt <= '0;
`endif
        end else begin
            state <= state_nxt;
            if (seed_ld) begin
                // all-zero would lock the LFSR up
                seed_q <= (seed_val == 32'h0) ? SEED_NONZERO : seed_val;
            end
`ifdef PRNG_SCHED_WARMUP_EN
            if (state == ST_LOAD) begin
                warm_cnt <= 8'(WARM_CYCLES);
            end else if (state == ST_WARM && warm_cnt != 8'd0) begin
                warm_cnt <= warm_cnt - 8'd1;
            end
`endif
        end
    end

    // Next state; a reseed wins over everything once a seed exists.
    always_comb begin
        state_nxt = state;
        case (state)
            ST_UNSEEDED: if (seed_ld) state_nxt = ST_LOAD;
            ST_LOAD: begin
                if (seed_ld) begin
                    state_nxt = ST_LOAD;
                end else begin
`ifdef PRNG_SCHED_WARMUP_EN
                    state_nxt = ST_WARM;
`else
                    state_nxt = ST_SERVE;
`endif
                end
            end
`ifdef PRNG_SCHED_WARMUP_EN
            ST_WARM: begin
                if (seed_ld)                state_nxt = ST_LOAD;
                else if (warm_cnt == 8'd1)  state_nxt = ST_SERVE;
            end
`endif
            ST_SERVE: if (seed_ld) state_nxt = ST_LOAD;
            default:  state_nxt = ST_UNSEEDED;
        endcase
    end

    // Strobes are gated by rst so an edge with reset low emits nothing.
    assign arb_en = rst && (state == ST_SERVE) && !seed_ld;

    rr_arb #(.NREQ(NREQ)) u_rr_arb (
        .clk (clk),
        .rst (rst),
        .req (req),
        .en  (arb_en),
        .clr (seed_ld),
        .gnt (gnt)
    );

    // Outputs.
    always_comb begin
        lfsr_ldval = seed_q;
        lfsr_ld    = rst && (state == ST_LOAD);
        rnd_vld    = |gnt;
        rnd_byte   = rnd_vld ? byte_fold(lfsr_val) : '0;
`ifdef PRNG_SCHED_WARMUP_EN
        busy      = (state == ST_LOAD) || (state == ST_WARM);
        lfsr_step = rnd_vld || (rst && !seed_ld && state == ST_WARM);
`else
        busy      = (state == ST_LOAD);
        lfsr_step = rnd_vld;
`endif
    end

endmodule

// File: tb/tb_prng_sched.sv
module tb_prng_sched;

    localparam int NREQ = 4;
`ifdef PRNG_SCHED_WARMUP_EN
    localparam int EXP_WARM = 16;
`else
    localparam int EXP_WARM = 0;
`endif

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] seed_val;
    logic        seed_ld;
    logic [3:0]  req;
    logic [3:0]  gnt;
    logic [7:0]  rnd_byte;
    logic        rnd_vld, busy, lfsr_ld, lfsr_step;
    logic [31:0] lfsr_ldval, lfsr_val;
    logic [31:0] lfsr_m = 32'hA5A5_0F0F;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    function automatic logic [31:0] lfsr_next(input logic [31:0] v);
        return v[0] ? ((v >> 1) ^ 32'h8020_0003) : (v >> 1);
    endfunction

    function automatic logic [7:0] fold(input logic [31:0] v);
        return v[7:0] ^ v[15:8] ^ v[23:16] ^ v[31:24];
    endfunction

    // stand-in for the external LFSR
    always @(posedge clk) begin
        if (lfsr_ld)        lfsr_m <= lfsr_ldval;
        else if (lfsr_step) lfsr_m <= lfsr_next(lfsr_m);
    end
    assign lfsr_val = lfsr_m;

    prng_sched #(.NREQ(NREQ), .WARM_CYCLES(16)) dut (
        .clk        (clk),
        .rst        (rst),
        .seed_val   (seed_val),
        .seed_ld    (seed_ld),
        .req        (req),
        .gnt        (gnt),
        .rnd_byte   (rnd_byte),
        .rnd_vld    (rnd_vld),
        .busy       (busy),
        .lfsr_ld    (lfsr_ld),
        .lfsr_ldval (lfsr_ldval),
        .lfsr_step  (lfsr_step),
        .lfsr_val   (lfsr_val)
    );

    task automatic test_reset();
        rst = 1'b0; req = 4'hF; seed_ld = 1'b1; seed_val = 32'h1234_5678;
        @(negedge clk);
        @(negedge clk);
        seed_ld = 1'b0;
        @(negedge clk); #1;
        total++; if (gnt !== 4'h0)         begin bad++; $display("FAIL reset_gnt: got %b want 0000", gnt); end
        total++; if (rnd_vld !== 1'b0)     begin bad++; $display("FAIL reset_vld: got %b want 0", rnd_vld); end
        total++; if (rnd_byte !== 8'h00)   begin bad++; $display("FAIL reset_byte: got %h want 00", rnd_byte); end
        total++; if (busy !== 1'b0)        begin bad++; $display("FAIL reset_busy: got %b want 0", busy); end
        total++; if (lfsr_ld !== 1'b0 || lfsr_step !== 1'b0)
                     begin bad++; $display("FAIL reset_strobes: got ld=%b step=%b want 0 0", lfsr_ld, lfsr_step); end
        total++; if (lfsr_ldval !== 32'h0) begin bad++; $display("FAIL reset_seed: got %h want 00000000", lfsr_ldval); end
    endtask

    task automatic test_unseeded();
        @(negedge clk);
        rst = 1'b1; req = 4'hF;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk); #1;
            total++;
            if (gnt !== 4'h0 || rnd_vld !== 1'b0 || lfsr_step !== 1'b0 || busy !== 1'b0) begin
                bad++;
                $display("FAIL unseeded[%0d]: got gnt=%b vld=%b step=%b busy=%b want 0000 0 0 0",
                         i, gnt, rnd_vld, lfsr_step, busy);
            end
        end
    endtask

    task automatic test_seed_load(input logic [31:0] sv, input logic [31:0] exp_ld, input string nm);
        int          busy_cnt, step_cnt, ld_cnt;
        logic [31:0] e;
        req = 4'h0;
        @(negedge clk);
        seed_val = sv; seed_ld = 1'b1;
        @(negedge clk);
        seed_ld = 1'b0; seed_val = 32'hFFFF_FFFF;
        #1;
        total++;
        if (lfsr_ld !== 1'b1 || lfsr_ldval !== exp_ld || lfsr_step !== 1'b0) begin
            bad++;
            $display("FAIL %s_load: got ld=%b val=%h step=%b want 1 %h 0", nm, lfsr_ld, lfsr_ldval, lfsr_step, exp_ld);
        end
        busy_cnt = busy ? 1 : 0; step_cnt = 0; ld_cnt = 1;
        for (int i = 0; i < 30; i++) begin
            @(negedge clk); #1;
            if (busy)      busy_cnt++;
            if (lfsr_step) step_cnt++;
            if (lfsr_ld)   ld_cnt++;
        end
        total++; if (busy_cnt != EXP_WARM + 1) begin bad++; $display("FAIL %s_busy_cycles: got %0d want %0d", nm, busy_cnt, EXP_WARM + 1); end
        total++; if (step_cnt != EXP_WARM)     begin bad++; $display("FAIL %s_warm_steps: got %0d want %0d", nm, step_cnt, EXP_WARM); end
        total++; if (ld_cnt != 1)              begin bad++; $display("FAIL %s_ld_cycles: got %0d want 1", nm, ld_cnt); end
        e = exp_ld;
        for (int i = 0; i < EXP_WARM; i++) e = lfsr_next(e);
        total++; if (lfsr_m !== e) begin bad++; $display("FAIL %s_lfsr_after_warm: got %h want %h", nm, lfsr_m, e); end
    endtask

    task automatic test_rr();
        logic [3:0] exp_g [9] = '{4'b0001, 4'b0010, 4'b1000, 4'b0001, 4'b0010,
                                  4'b1000, 4'b0001, 4'b0010, 4'b1000};
        for (int i = 0; i < 9; i++) begin
            @(negedge clk);
            req = 4'b1011;
            #1;
            total++;
            if (gnt !== exp_g[i] || rnd_vld !== 1'b1 || rnd_byte !== fold(lfsr_m) ||
                lfsr_step !== 1'b1 || lfsr_ld !== 1'b0) begin
                bad++;
                $display("FAIL rr[%0d]: got gnt=%b vld=%b byte=%h step=%b ld=%b want %b 1 %h 1 0",
                         i, gnt, rnd_vld, rnd_byte, lfsr_step, lfsr_ld, exp_g[i], fold(lfsr_m));
            end
        end
    endtask

    task automatic test_idle();
        logic [31:0] m;
        @(negedge clk);
        req = 4'h0;
        #1;
        m = lfsr_m;
        total++;
        if (gnt !== 4'h0 || rnd_vld !== 1'b0 || lfsr_step !== 1'b0 || rnd_byte !== 8'h00) begin
            bad++;
            $display("FAIL idle: got gnt=%b vld=%b step=%b byte=%h want 0000 0 0 00", gnt, rnd_vld, lfsr_step, rnd_byte);
        end
        @(negedge clk); #1;
        total++; if (lfsr_m !== m) begin bad++; $display("FAIL idle_hold: got %h want %h", lfsr_m, m); end
    endtask

    task automatic test_back_to_back();
        logic [3:0] exp_all [8] = '{4'b0001, 4'b0010, 4'b0100, 4'b1000,
                                    4'b0001, 4'b0010, 4'b0100, 4'b1000};
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            req = 4'b1111;
            #1;
            total++;
            if (gnt !== exp_all[i] || rnd_byte !== fold(lfsr_m)) begin
                bad++;
                $display("FAIL b2b_all[%0d]: got gnt=%b byte=%h want %b %h", i, gnt, rnd_byte, exp_all[i], fold(lfsr_m));
            end
        end
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            req = 4'b0100;
            #1;
            total++;
            if (gnt !== 4'b0100 || lfsr_step !== 1'b1) begin
                bad++;
                $display("FAIL b2b_single[%0d]: got gnt=%b step=%b want 0100 1", i, gnt, lfsr_step);
            end
        end
    endtask

    task automatic test_reseed_stream();
        int k;
        @(negedge clk);
        req = 4'b1111;
        #1;
        total++; if (gnt !== 4'b1000) begin bad++; $display("FAIL stream_pre: got %b want 1000", gnt); end
        @(negedge clk);
        seed_val = 32'h0BAD_F00D; seed_ld = 1'b1;
        #1;
        total++;
        if (gnt !== 4'h0 || lfsr_step !== 1'b0 || rnd_vld !== 1'b0) begin
            bad++;
            $display("FAIL reseed_cycle: got gnt=%b step=%b vld=%b want 0000 0 0", gnt, lfsr_step, rnd_vld);
        end
        @(negedge clk);
        seed_ld = 1'b0;
        #1;
        total++;
        if (lfsr_ld !== 1'b1 || lfsr_ldval !== 32'h0BAD_F00D || gnt !== 4'h0) begin
            bad++;
            $display("FAIL reseed_load: got ld=%b val=%h gnt=%b want 1 0badf00d 0000", lfsr_ld, lfsr_ldval, gnt);
        end
        k = -1;
        for (int i = 1; i <= 40; i++) begin
            @(negedge clk); #1;
            if (gnt !== 4'h0) begin k = i; break; end
        end
        total++; if (k != EXP_WARM + 1) begin bad++; $display("FAIL reseed_first_grant_cycle: got %0d want %0d", k, EXP_WARM + 1); end
        total++; if (gnt !== 4'b0001)   begin bad++; $display("FAIL reseed_first_grant: got %b want 0001", gnt); end
    endtask

    task automatic test_rst_mid();
        logic [31:0] m;
        req = 4'b1111;
        @(negedge clk);
        rst = 1'b0;
        #1;
        total++;
        if (gnt !== 4'h0 || lfsr_step !== 1'b0 || lfsr_ld !== 1'b0) begin
            bad++;
            $display("FAIL rst_serve: got gnt=%b step=%b ld=%b want 0000 0 0", gnt, lfsr_step, lfsr_ld);
        end
        @(negedge clk);
        rst = 1'b1;
        #1;
        total++; if (gnt !== 4'h0 || busy !== 1'b0) begin bad++; $display("FAIL rst_serve_after: got gnt=%b busy=%b want 0000 0", gnt, busy); end
        @(negedge clk);
        seed_val = 32'h1357_9BDF; seed_ld = 1'b1;
        @(negedge clk);
        seed_ld = 1'b0;
        @(negedge clk); #1;
        total++; if (lfsr_step !== 1'b1) begin bad++; $display("FAIL rst_pre_step: got %b want 1", lfsr_step); end
        @(negedge clk);
        rst = 1'b0;
        #1;
        m = lfsr_m;
        total++;
        if (lfsr_step !== 1'b0 || lfsr_ld !== 1'b0) begin
            bad++;
            $display("FAIL rst_mid: got step=%b ld=%b want 0 0", lfsr_step, lfsr_ld);
        end
        @(negedge clk);
        rst = 1'b1;
        for (int i = 0; i < 5; i++) begin
            #1;
            total++;
            if (lfsr_step !== 1'b0 || lfsr_ld !== 1'b0 || busy !== 1'b0 || gnt !== 4'h0 || lfsr_m !== m) begin
                bad++;
                $display("FAIL rst_mid_after[%0d]: got step=%b ld=%b busy=%b gnt=%b lfsr=%h want 0 0 0 0000 %h",
                         i, lfsr_step, lfsr_ld, busy, gnt, lfsr_m, m);
            end
            @(negedge clk);
        end
    endtask

    initial begin
        rst = 1'b0; seed_ld = 1'b0; seed_val = 32'h0; req = 4'h0;
        test_reset();
        test_unseeded();
        test_seed_load(32'hDEAD_BEEF, 32'hDEAD_BEEF, "seed_deadbeef");
        test_rr();
        test_idle();
        test_back_to_back();
        test_reseed_stream();
        test_seed_load(32'h0000_0000, 32'h0000_0001, "seed_zero");
        test_rst_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
